// File: rtl/vga_sync.sv
// vga_sync: VGA timing generator with a pixel-rate enable divider,
// nested horizontal/vertical counters, registered sync/blank outputs
// and a mouse-coordinate hand-off to the renderer.
// Optional macro VGA_SYNC_MOUSE_LATCH_EN: when defined, the mouse
// coordinates only update on the frame_tick edge, so they stay stable
// for a whole frame. When undefined, they are a 1-clk registered copy.
module vga_sync #(
  parameter int CLK_DIV   = 4,
  parameter int H_DISPLAY = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_DISPLAY = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] mouse_x_in,
  input  logic [9:0] mouse_y_in,
  output logic [9:0] pix_x,
  output logic [9:0] pix_y,
  output logic       video_on,
  output logic       hsync,
  output logic       vsync,
  output logic       p_tick,
  output logic       line_tick,
  output logic       frame_tick,
  output logic [9:0] mouse_x,
  output logic [9:0] mouse_y
);

  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
  // A divide-by-1 still needs a 1-bit counter so the compare is legal.
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_DISPLAY);
  localparam logic [9:0] V_VIS    = 10'(V_DISPLAY);
  localparam logic [9:0] HS_START = 10'(H_DISPLAY + H_FRONT);
  localparam logic [9:0] HS_END   = 10'(H_DISPLAY + H_FRONT + H_SYNC);
  localparam logic [9:0] VS_START = 10'(V_DISPLAY + V_FRONT);
  localparam logic [9:0] VS_END   = 10'(V_DISPLAY + V_FRONT + V_SYNC);

  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic [9:0]       pix_x_q, pix_x_d;
  logic [9:0]       pix_y_q, pix_y_d;
  logic             video_on_q, video_on_d;
  logic             hsync_q, hsync_d;
  logic             vsync_q, vsync_d;
  logic             p_tick_q, p_tick_d;
  logic             line_tick_q, line_tick_d;
  logic             frame_tick_q, frame_tick_d;
  logic [9:0]       mouse_x_q, mouse_x_d;
  logic [9:0]       mouse_y_q, mouse_y_d;
  logic             advance;

  assign advance = (div_cnt_q == DIV_LAST);

  // Next-state counters, and every output decoded from those next values
  // so the registered outputs line up with the counters they describe.
  always_comb begin
    div_cnt_d = advance ? '0 : div_cnt_q + DIV_W'(1);
    pix_x_d   = pix_x_q;
    pix_y_d   = pix_y_q;
    if (advance) begin
      if (pix_x_q == H_LAST) begin
        pix_x_d = '0;
        pix_y_d = (pix_y_q == V_LAST) ? 10'd0 : pix_y_q + 10'd1;
      end else begin
        pix_x_d = pix_x_q + 10'd1;
      end
    end

    video_on_d   = (pix_x_d < H_VIS) && (pix_y_d < V_VIS);
    hsync_d      = !((pix_x_d >= HS_START) && (pix_x_d < HS_END));
    vsync_d      = !((pix_y_d >= VS_START) && (pix_y_d < VS_END));
    p_tick_d     = advance;
    line_tick_d  = advance && (pix_x_d == 10'd0);
    frame_tick_d = line_tick_d && (pix_y_d == 10'd0);

`ifdef VGA_SYNC_MOUSE_LATCH_EN
    mouse_x_d = frame_tick_d ? mouse_x_in : mouse_x_q;
    mouse_y_d = frame_tick_d ? mouse_y_in : mouse_y_q;
`else
    mouse_x_d = mouse_x_in;
    mouse_y_d = mouse_y_in;
`endif
  end

  // State registers with synchronous reset back to the idle origin.
  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt_q    <= '0;
      pix_x_q      <= '0;
      pix_y_q      <= '0;
      video_on_q   <= 1'b0;
      hsync_q      <= 1'b1;
      vsync_q      <= 1'b1;
      p_tick_q     <= 1'b0;
      line_tick_q  <= 1'b0;
      frame_tick_q <= 1'b0;
      mouse_x_q    <= '0;
      mouse_y_q    <= '0;
    end else begin
      div_cnt_q    <= div_cnt_d;
      pix_x_q      <= pix_x_d;
      pix_y_q      <= pix_y_d;
      video_on_q   <= video_on_d;
      hsync_q      <= hsync_d;
      vsync_q      <= vsync_d;
      p_tick_q     <= p_tick_d;
      line_tick_q  <= line_tick_d;
      frame_tick_q <= frame_tick_d;
      mouse_x_q    <= mouse_x_d;
      mouse_y_q    <= mouse_y_d;
    end
  end

  assign pix_x      = pix_x_q;
  assign pix_y      = pix_y_q;
  assign video_on   = video_on_q;
  assign hsync      = hsync_q;
  assign vsync      = vsync_q;
  assign p_tick     = p_tick_q;
  assign line_tick  = line_tick_q;
  assign frame_tick = frame_tick_q;
  assign mouse_x    = mouse_x_q;
  assign mouse_y    = mouse_y_q;

endmodule

// File: tb/tb_vga_sync.sv
// tb_vga_sync: randomized bench for vga_sync. Two instances share the
// stimulus: A divides by 4 with a small raster, B divides by 1 with the
// tiny 7x6 raster. Expected values come from the clock count since
// reset release, turned into a raster position with plain arithmetic.
module tb_vga_sync;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic       von;
    logic       hs;
    logic       vs;
    logic       pt;
    logic       lt;
    logic       ft;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [9:0] mouse_x_in;
  logic [9:0] mouse_y_in;

  logic [9:0] a_pix_x, a_pix_y, a_mouse_x, a_mouse_y;
  logic       a_video_on, a_hsync, a_vsync, a_p_tick, a_line_tick, a_frame_tick;
  logic [9:0] b_pix_x, b_pix_y, b_mouse_x, b_mouse_y;
  logic       b_video_on, b_hsync, b_vsync, b_p_tick, b_line_tick, b_frame_tick;

  exp_t obs_a, obs_b, exp_a, exp_b;
  int   checks = 0;
  int   errors = 0;
  int   t_rel  = 0;
  logic [9:0] mx_exp_a, my_exp_a, mx_exp_b, my_exp_b;

  always #5 clk = ~clk;

  vga_sync #(
    .CLK_DIV(4), .H_DISPLAY(10), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
    .V_DISPLAY(6), .V_FRONT(2), .V_SYNC(2), .V_BACK(2)
  ) u_dut_a (
    .clk(clk), .reset(reset), .mouse_x_in(mouse_x_in), .mouse_y_in(mouse_y_in),
    .pix_x(a_pix_x), .pix_y(a_pix_y), .video_on(a_video_on),
    .hsync(a_hsync), .vsync(a_vsync), .p_tick(a_p_tick),
    .line_tick(a_line_tick), .frame_tick(a_frame_tick),
    .mouse_x(a_mouse_x), .mouse_y(a_mouse_y)
  );

  vga_sync #(
    .CLK_DIV(1), .H_DISPLAY(4), .H_FRONT(1), .H_SYNC(1), .H_BACK(1),
    .V_DISPLAY(3), .V_FRONT(1), .V_SYNC(1), .V_BACK(1)
  ) u_dut_b (
    .clk(clk), .reset(reset), .mouse_x_in(mouse_x_in), .mouse_y_in(mouse_y_in),
    .pix_x(b_pix_x), .pix_y(b_pix_y), .video_on(b_video_on),
    .hsync(b_hsync), .vsync(b_vsync), .p_tick(b_p_tick),
    .line_tick(b_line_tick), .frame_tick(b_frame_tick),
    .mouse_x(b_mouse_x), .mouse_y(b_mouse_y)
  );

  assign obs_a = {a_pix_x, a_pix_y, a_video_on, a_hsync, a_vsync,
                  a_p_tick, a_line_tick, a_frame_tick};
  assign obs_b = {b_pix_x, b_pix_y, b_video_on, b_hsync, b_vsync,
                  b_p_tick, b_line_tick, b_frame_tick};

  // Raster position after t clocks since reset release (t=0: reset state).
  function automatic exp_t rasterModel(input int t, input int cd,
                                       input int hd, input int hf, input int hs, input int hb,
                                       input int vd, input int vf, input int vs, input int vb);
    exp_t e;
    int ht, vt, adv, pos, x, y;
    e = '0;
    e.hs = 1'b1;
    e.vs = 1'b1;
    if (t > 0) begin
      ht   = hd + hf + hs + hb;
      vt   = vd + vf + vs + vb;
      adv  = t / cd;
      pos  = adv % (ht * vt);
      x    = pos % ht;
      y    = pos / ht;
      e.x  = 10'(x);
      e.y  = 10'(y);
      e.von = (x < hd) && (y < vd);
      e.hs = !((x >= hd + hf) && (x < hd + hf + hs));
      e.vs = !((y >= vd + vf) && (y < vd + vf + vs));
      e.pt = (t % cd) == 0;
      e.lt = e.pt && (x == 0);
      e.ft = e.pt && (pos == 0);
    end
    return e;
  endfunction

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Compares one instance's outputs field by field against the model.
  task automatic checkInstance(input string name, input exp_t o, input exp_t e,
                               input logic [9:0] mx, input logic [9:0] my,
                               input logic [9:0] mxe, input logic [9:0] mye);
    checkOutput({name, ".pix_x"},      32'(o.x),  32'(e.x));
    checkOutput({name, ".pix_y"},      32'(o.y),  32'(e.y));
    checkOutput({name, ".video_on"},   32'(o.von), 32'(e.von));
    checkOutput({name, ".hsync"},      32'(o.hs), 32'(e.hs));
    checkOutput({name, ".vsync"},      32'(o.vs), 32'(e.vs));
    checkOutput({name, ".p_tick"},     32'(o.pt), 32'(e.pt));
    checkOutput({name, ".line_tick"},  32'(o.lt), 32'(e.lt));
    checkOutput({name, ".frame_tick"}, 32'(o.ft), 32'(e.ft));
    checkOutput({name, ".mouse_x"},    32'(mx),   32'(mxe));
    checkOutput({name, ".mouse_y"},    32'(my),   32'(mye));
  endtask

  // Drives inputs on the falling edge, away from the sampling edge.
  task automatic applyStimulus(input logic r, input logic [9:0] mx, input logic [9:0] my);
    @(negedge clk);
    reset      = r;
    mouse_x_in = mx;
    mouse_y_in = my;
  endtask

  initial begin
    logic       r;
    logic [9:0] mx, my;
    reset      = 1'b1;
    mouse_x_in = '0;
    mouse_y_in = '0;
    mx = 10'd10;
    my = 10'd20;
    mx_exp_a = '0; my_exp_a = '0; mx_exp_b = '0; my_exp_b = '0;

    for (int cyc = 0; cyc < 6000; cyc++) begin
      if (cyc < 3 || cyc == 1500)
        r = 1'b1;
      else
        r = ($urandom_range(0, 599) == 0);
      if ($urandom_range(0, 7) == 0) begin
        mx = 10'($urandom_range(0, 1023));
        my = 10'($urandom_range(0, 1023));
      end
      applyStimulus(r, mx, my);
      @(posedge clk);

      t_rel = r ? 0 : t_rel + 1;
      exp_a = rasterModel(t_rel, 4, 10, 2, 3, 2, 6, 2, 2, 2);
      exp_b = rasterModel(t_rel, 1, 4, 1, 1, 1, 3, 1, 1, 1);
      if (r) begin
        mx_exp_a = '0; my_exp_a = '0; mx_exp_b = '0; my_exp_b = '0;
      end else begin
`ifdef VGA_SYNC_MOUSE_LATCH_EN
        if (exp_a.ft) begin mx_exp_a = mx; my_exp_a = my; end
        if (exp_b.ft) begin mx_exp_b = mx; my_exp_b = my; end
`else
        mx_exp_a = mx; my_exp_a = my; mx_exp_b = mx; my_exp_b = my;
`endif
      end

      #1;
      checkInstance("A", obs_a, exp_a, a_mouse_x, a_mouse_y, mx_exp_a, my_exp_a);
      checkInstance("B", obs_b, exp_b, b_mouse_x, b_mouse_y, mx_exp_b, my_exp_b);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_sync.md
Name: vga_sync

Overview:
- Timing generator that produces the `pix_x`/`pix_y`/`video_on` stream consumed by the graphics renderer, plus the `hsync`/`vsync` pins for the VGA connector.
- Derives a pixel-rate enable from the system clock and runs nested horizontal and vertical counters.
- Also hands the renderer a per-frame-stable copy of the mouse coordinates.
- Sits between the PS/2 mouse front end and the graphics block, in the top level.

Parameters:
- CLK_DIV, 4, system clocks per pixel (100 MHz clk -> 25 MHz pixel); must be >= 1.
- H_DISPLAY, 640, visible pixels per line.
- H_FRONT, 16, horizontal front porch in pixels.
- H_SYNC, 96, hsync pulse width in pixels.
- H_BACK, 48, horizontal back porch in pixels.
- V_DISPLAY, 480, visible lines per frame.
- V_FRONT, 10, vertical front porch in lines.
- V_SYNC, 2, vsync pulse width in lines.
- V_BACK, 33, vertical back porch in lines.

Ports:
- clk  in  1  system clock, single clock domain.
- reset  in  1  synchronous, active-high reset.
- mouse_x_in  in  10  raw mouse x from mouse front end.
- mouse_y_in  in  10  raw mouse y from mouse front end.
- pix_x  out  10  current horizontal pixel count.
- pix_y  out  10  current vertical line count.
- video_on  out  1  current pixel is in the visible area.
- hsync  out  1  horizontal sync, active low.
- vsync  out  1  vertical sync, active low.
- p_tick  out  1  one-clk pulse; counters advanced this cycle.
- line_tick  out  1  one-clk pulse when pix_x wraps to 0.
- frame_tick  out  1  one-clk pulse when (pix_x,pix_y) wraps to (0,0).
- mouse_x  out  10  mouse x delivered to the renderer.
- mouse_y  out  10  mouse y delivered to the renderer.

Behaviour:
- Derived totals: H_TOTAL = sum of the four H parameters (800); V_TOTAL = sum of the four V parameters (525). Both must fit in 10 bits.
- Reset values:
  - div counter, pix_x, pix_y, mouse_x, mouse_y = 0.
  - hsync = vsync = 1.
  - video_on, p_tick, line_tick, frame_tick = 0.
- Reset asserted mid-frame returns everything to these values on the next clk edge, with no partial line.
- Divider:
  - div_cnt counts 0..CLK_DIV-1 and wraps.
  - An advance occurs on the cycle where div_cnt == CLK_DIV-1.
  - First advance is the CLK_DIV-th clock after reset release.
  - CLK_DIV=1 means an advance every cycle.
- Counters (update only on an advance):
  - pix_x increments; at H_TOTAL-1 it wraps to 0 and pix_y increments.
  - pix_y wraps from V_TOTAL-1 to 0 on the same edge that pix_x wraps.
- All outputs are registers computed from next-state counter values, so every cycle they describe the current pix_x/pix_y with zero skew:
  - video_on = (pix_x < H_DISPLAY) && (pix_y < V_DISPLAY). Holds from the first clk after reset release; video_on becomes 1 on that clk.
  - hsync = 0 iff H_DISPLAY+H_FRONT <= pix_x < H_DISPLAY+H_FRONT+H_SYNC (656..751).
  - vsync = 0 iff V_DISPLAY+V_FRONT <= pix_y < V_DISPLAY+V_FRONT+V_SYNC (490..491).
  - p_tick = 1 for exactly the cycle in which the new counter values first appear.
  - line_tick = 1 in that same cycle when new pix_x == 0.
  - frame_tick = 1 in that same cycle when the new values are (0,0).
  - The initial reset state (0,0) does not generate frame_tick or line_tick.
- No back-pressure and no handshake: the downstream side samples freely.
- Mouse path (default): mouse_x/mouse_y are registered copies of the inputs, 1 clk latency, updated every cycle.

Optional Feature:
- Macro: VGA_SYNC_MOUSE_LATCH_EN.
- Defined:
  - mouse_x/mouse_y load mouse_x_in/mouse_y_in only on the clk edge that produces frame_tick = 1, i.e. they change together with (0,0), and hold otherwise.
  - Prevents tearing of the rope drawing mid-frame.
  - Values captured are those present on the inputs in the cycle before frame_tick.
- Undefined: 1-clk registered pass-through as described above.
- Both variants keep identical ports and reset values.

Test Plan:
- Reset then release with defaults → all outputs at the reset values; p_tick first high at clk 4 after release, then every 4 clks; video_on = 1 from clk 1.
- Run one line → hsync low for exactly 96 pixel advances (pix_x 656..751 = 384 clks); line_tick period 3200 clks; video_on falls as pix_x goes 639→640.
- Run one full frame → vsync low only while pix_y in 490..491; frame_tick period 1,680,000 clks, coincident with pix_x = pix_y = 0; video_on = 1 at (639,479) and 0 at (0,480).
- Small params (CLK_DIV=1, H 4/1/1/1, V 3/1/1/1) → pix_x sequence 0..6 wraps, pix_y 0..5 wraps; frame_tick every 42 clks; no skew between pix_x and hsync.
- Assert reset at pix_x=300, pix_y=200 → next clk pix_x = pix_y = 0, hsync = vsync = 1, video_on = 0; normal timing resumes identically.
- Mouse path:
  - Without macro: mouse_x_in = 123 → mouse_x = 123 one clk later.
  - With VGA_SYNC_MOUSE_LATCH_EN: input changed mid-frame from 10 to 123 → mouse_x stays 10 until the frame_tick edge, then becomes 123.
